// File: rtl/mem_dump_reader.sv
// mem_dump_reader: reads a contiguous, wrapping window of a synchronous-read
// memory and streams the words out on a valid/ready interface.
//
// state | meaning
// IDLE  | waiting for start; first read is issued on the accept edge
// RUN   | issuing reads and draining the 2-entry output buffer
// FIN   | one-cycle done pulse, then back to IDLE
module mem_dump_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] adr,
    input  logic [DATA_WIDTH-1:0] dat_r,
    output logic [DATA_WIDTH-1:0] dat_w,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state_q, state_d;

    logic [ADDR_WIDTH:0]   cnt_q;
    logic [ADDR_WIDTH:0]   issued_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [1:0]            buf_last_q;
    logic [1:0]            occ_q;
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  issue_last;
    logic [ADDR_WIDTH-1:0] issue_adr;
    logic [2:0]            pending;
    logic [2:0]            limit;

    assign dat_w     = '0;
    assign we        = 1'b0;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = buf_data_q[rd_ptr_q];
    assign out_last  = out_valid & buf_last_q[rd_ptr_q];
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q;

    // Words buffered plus the one in flight must stay within the 2-entry buffer.
    assign pending   = {1'b0, occ_q} + {2'b00, inflight_q};
    assign limit     = 3'd2 + {2'b00, pop};

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_adr  = adr;
        busy       = (state_q != IDLE);
        done       = (state_q == FIN);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = (count == '0) ? FIN : RUN;
                    issue      = (count != '0);
                    issue_last = (count == (ADDR_WIDTH+1)'(1));
                    issue_adr  = base;
                end
            end
            RUN: begin
                if ((issued_q < cnt_q) && (pending < limit)) begin
                    issue      = 1'b1;
                    issue_last = ((issued_q + (ADDR_WIDTH+1)'(1)) == cnt_q);
                    issue_adr  = adr + ADDR_WIDTH'(1);
                end
                if (pop && out_last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adr             <= '0;
            cnt_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_data_q[0]   <= '0;
            buf_data_q[1]   <= '0;
            buf_last_q      <= '0;
            occ_q           <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (start) begin
                    cnt_q <= count;
                end
                issued_q <= {{ADDR_WIDTH{1'b0}}, issue};
            end else if (issue) begin
                issued_q <= issued_q + (ADDR_WIDTH+1)'(1);
            end
            inflight_q <= issue;
            if (issue) begin
                adr             <= issue_adr;
                inflight_last_q <= issue_last;
            end
            if (push) begin
                buf_data_q[wr_ptr_q] <= dat_r;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
- Bus initiator for the single-port synchronous-read memory block; the read side that pairs with that memory's responder role.
- On a start pulse it sweeps a contiguous address window, starting at a base address and wrapping modulo the memory depth.
- It streams the read words out on a valid/ready interface with full backpressure support.
- It sits between the memory's adr/dat_r/dat_w/we port and a downstream consumer such as a debug dump path or checksum unit.

Parameters:
ADDR_WIDTH, 4, memory address width; depth = 2^ADDR_WIDTH
DATA_WIDTH, 8, memory word width

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only when idle
base  in  ADDR_WIDTH  first address of the sweep, sampled with start
count  in  ADDR_WIDTH+1  number of words to read, 0..2^ADDR_WIDTH, sampled with start
busy  out  1  high from the start-accept edge until done
done  out  1  one-cycle pulse at the end of the sweep
adr  out  ADDR_WIDTH  memory address
dat_r  in  DATA_WIDTH  memory read data; valid the cycle after adr is presented
dat_w  out  DATA_WIDTH  memory write data; constant 0
we  out  1  memory write enable; constant 0
out_data  out  DATA_WIDTH  stream data
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_last  out  1  qualifies the final word of the sweep

Behaviour:
- Reset values: busy=0, done=0, adr=0, out_valid=0, out_last=0, out_data=0. Any in-flight read and any buffered words are discarded.
- Reset mid-sweep aborts the sweep immediately. No done pulse is produced.
- FSM states are IDLE, RUN and FIN.
  - IDLE: start=1 latches base and count, sets busy. Goes to FIN if count=0, otherwise to RUN.
  - RUN: issues reads. Goes to FIN once the last word has been accepted by the consumer (out_valid & out_ready & out_last).
  - FIN: done=1 for exactly one cycle, busy drops, returns to IDLE.
- start is ignored while busy.
- Read issue:
  - adr is registered. The i-th issued read presents adr = (base + i) mod 2^ADDR_WIDTH; wrap is natural truncation.
  - The word for that address is captured from dat_r at the following edge into a 2-entry output buffer.
  - One read may be in flight at a time per cycle.
  - Issue condition: RUN, words issued < count, and occ + inflight - pop < 2, where pop = out_valid & out_ready in the current cycle.
  - This sustains 1 word/cycle when out_ready is held at 1.
  - The buffer never holds more than 2 words; no word is dropped or duplicated.
- adr holds its last value when no read is issued.
- Latency: with start accepted at edge E0, adr=base is driven after E0, data is captured at E1, and out_valid=1 after E1. The first word is therefore visible one cycle after the start edge plus the memory latency.
- Stream rules:
  - out_data and out_last are stable while out_valid & !out_ready.
  - out_valid never drops without a handshake, except on rst.
  - out_last=1 only on word index count-1.
- done asserts in the cycle after the last handshake. busy=1 through that done cycle's edge and is 0 afterwards.
- count = 2^ADDR_WIDTH reads every location exactly once, starting at base.
- we=0 and dat_w=0 at all times, including during reset.

Test Plan:
- Memory preloaded with mem[i]=0x10+i. base=0, count=16, out_ready=1 -> words 0x10..0x1F on 16 consecutive cycles; out_last only with 0x1F; done one cycle later; busy then 0.
- base=14, count=4 -> adr sequence 14,15,0,1; out_data 0x1E,0x1F,0x10,0x11; out_last on 0x11.
- base=5, count=0 -> done pulses one cycle after start; out_valid never asserts; adr unchanged.
- base=0, count=6, out_ready low for 5 cycles then toggling 1,0,1,0 -> out_data held stable while stalled; exactly 0x10..0x15 delivered in order; occupancy never exceeds 2; we=0 throughout.
- rst asserted after 3 handshakes of a count=8 sweep -> next cycle out_valid=0, busy=0, no done pulse. A following start with base=3, count=2 yields 0x13,0x14 with done.
- start pulsed again mid-sweep with base=9 -> ignored; the original sweep completes unchanged.
